convolution_3x3_dilation: RTL and testbench

- Streaming 3x3 binary morphological dilation for the vision pipeline. Runs after the colour-threshold mask stage and before blob/centroid detection.
- Accepts one 1-bit pixel per clock in raster order and keeps two line buffers.
- Outputs the OR of the 3x3 neighbourhood around each centre pixel, with zero padding outside the image.
- Exposes internal counters and taps as debug outputs.

---
 rtl/vision_pkg.sv | 19 +
 rtl/line_buffer_1b.sv | 25 ++
 rtl/convolution_3x3_dilation.sv | 118 +++++++++++
 tb/tb_convolution_3x3_dilation.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/vision_pkg.sv
// Shared constants for the binary vision pipeline blocks.
// Counter widths are fixed; image size is a parameter of each block.
package vision_pkg;

  localparam int IMG_WIDTH_DEFAULT  = 9;
  localparam int IMG_HEIGHT_DEFAULT = 8;
  localparam int COL_W              = 9;
  localparam int ROW_W              = 4;
  localparam int SU_W               = 5;

  // Startup saturation point: one full line plus one pixel, limited by SU_W.
  function automatic logic [SU_W-1:0] startup_limit(input int width);
    if (width + 1 > 31) begin
      return SU_W'(31);
    end
    return SU_W'(width + 1);
  endfunction

endpackage

// File: rtl/line_buffer_1b.sv
// One-bit shift register of DEPTH stages with enable; the oldest bit is
// presented on o_dout, so it lags i_din by DEPTH accepted samples.
module line_buffer_1b #(
  parameter int DEPTH = 9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_din,
  output logic o_dout
);

  logic [DEPTH-1:0] r_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
    end else if (i_en) begin
      r_shift <= {r_shift[DEPTH-2:0], i_din};
    end
  end

  assign o_dout = r_shift[DEPTH-1];

endmodule

// File: rtl/convolution_3x3_dilation.sv
// Streaming 3x3 binary dilation with zero padding. Two line buffers feed a
// shifting window; delayed counters track the window centre for edge masking.
module convolution_3x3_dilation
  import vision_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEFAULT,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_pixel,
  input  logic             i_pixel_valid,
  output logic             o_pixel,
  output logic [COL_W-1:0] pixelCounter1,
  output logic [ROW_W-1:0] pixelRowCounter1,
  output logic [SU_W-1:0]  pixelStartUpCounter_check,
  output logic             pixelEnable_check,
  output logic             tap0,
  output logic             tap1
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [SU_W-1:0]  SU_MAX   = startup_limit(IMG_WIDTH);

  logic [COL_W-1:0] r_col, r_ccol;
  logic [ROW_W-1:0] r_row, r_crow;
  logic [SU_W-1:0]  r_startup;
  logic             r_enable;
  logic             r_out;
  logic             w_tap0, w_tap1;
  logic [2:0]       w_new_col;
  logic [2:0]       w_col_mask;
  logic [2:0]       w_row_ok;
  logic [8:0]       w_masked;

  line_buffer_1b #(.DEPTH(IMG_WIDTH)) u_lb0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (i_pixel_valid),
    .i_din  (i_pixel),
    .o_dout (w_tap0)
  );

  line_buffer_1b #(.DEPTH(IMG_WIDTH)) u_lb1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (i_pixel_valid),
    .i_din  (w_tap0),
    .o_dout (w_tap1)
  );

  // Row index 0 is the top of the window; bit 2 of each row is its left column.
  assign w_new_col  = {i_pixel, w_tap0, w_tap1};
  assign w_col_mask = {r_ccol != '0, 1'b1, r_ccol != LAST_COL};
  assign w_row_ok   = {r_crow != LAST_ROW, 1'b1, r_crow != '0};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_row
      logic [2:0] r_win;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_win <= '0;
        end else if (i_pixel_valid) begin
          r_win <= {r_win[1:0], w_new_col[gi]};
        end
      end

      assign w_masked[gi*3 +: 3] = r_win & w_col_mask & {3{w_row_ok[gi]}};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col     <= '0;
      r_row     <= '0;
      r_ccol    <= '0;
      r_crow    <= '0;
      r_startup <= '0;
      r_enable  <= 1'b0;
      r_out     <= 1'b0;
    end else if (i_pixel_valid) begin
      if (r_col == LAST_COL) begin
        r_col <= '0;
        r_row <= (r_row == LAST_ROW) ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end

      if (r_startup != SU_MAX) begin
        r_startup <= r_startup + SU_W'(1);
      end
      r_enable <= r_enable | (r_startup == SU_MAX);

      // The centre only starts moving once it sits on pixel (0,0).
      if (r_enable) begin
        if (r_ccol == LAST_COL) begin
          r_ccol <= '0;
          r_crow <= (r_crow == LAST_ROW) ? '0 : r_crow + ROW_W'(1);
        end else begin
          r_ccol <= r_ccol + COL_W'(1);
        end
      end

      r_out <= r_enable & (|w_masked);
    end
  end

  assign o_pixel                   = r_out;
  assign pixelCounter1             = r_col;
  assign pixelRowCounter1          = r_row;
  assign pixelStartUpCounter_check = r_startup;
  assign pixelEnable_check         = r_enable;
  assign tap0                      = w_tap0;
  assign tap1                      = w_tap1;

endmodule

// File: tb/tb_convolution_3x3_dilation.sv
// Directed bench for convolution_3x3_dilation: streams 9x8 frames and checks
// every output after each clock against a plain 2-D dilation of each frame.
module tb_convolution_3x3_dilation;

  localparam int W = 9;
  localparam int H = 8;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_pixel = 1'b0;
  logic       i_pixel_valid = 1'b0;
  logic       o_pixel;
  logic [8:0] pixelCounter1;
  logic [3:0] pixelRowCounter1;
  logic [4:0] pixelStartUpCounter_check;
  logic       pixelEnable_check;
  logic       tap0;
  logic       tap1;

  convolution_3x3_dilation #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .i_pixel                   (i_pixel),
    .i_pixel_valid             (i_pixel_valid),
    .o_pixel                   (o_pixel),
    .pixelCounter1             (pixelCounter1),
    .pixelRowCounter1          (pixelRowCounter1),
    .pixelStartUpCounter_check (pixelStartUpCounter_check),
    .pixelEnable_check         (pixelEnable_check),
    .tap0                      (tap0),
    .tap1                      (tap1)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  logic img   [N];
  logic hist  [2048];
  logic dil_s [2048];
  int   acc = 0;
  int   frames = 0;
  logic exp_o = 1'b0;
  int   ones = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected state derived from the number of pixels accepted since reset.
  task automatic check_state();
    int   su_exp;
    logic t0_exp;
    logic t1_exp;
    su_exp = (acc > W + 1) ? W + 1 : acc;
    t0_exp = 1'b0;
    t1_exp = 1'b0;
    if (acc >= W)     t0_exp = hist[acc - W];
    if (acc >= 2 * W) t1_exp = hist[acc - 2 * W];
    chk("o_pixel", 16'(o_pixel), 16'(exp_o));
    chk("col", 16'(pixelCounter1), 16'(acc % W));
    chk("row", 16'(pixelRowCounter1), 16'((acc / W) % H));
    chk("startup", 16'(pixelStartUpCounter_check), 16'(su_exp));
    chk("enable", 16'(pixelEnable_check), 16'(acc >= W + 2));
    chk("tap0", 16'(tap0), 16'(t0_exp));
    chk("tap1", 16'(tap1), 16'(t1_exp));
  endtask

  // Builds a frame and appends its zero-padded dilation to the output stream.
  task automatic load_frame(input int kind);
    logic d;
    for (int i = 0; i < N; i++) img[i] = 1'b0;
    case (kind)
      1: begin
        img[3*W+2] = 1'b1; img[3*W+3] = 1'b1;
        img[4*W+2] = 1'b1; img[4*W+3] = 1'b1;
      end
      2: img[0] = 1'b1;
      3: img[7*W+8] = 1'b1;
      default: ;
    endcase
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        d = 1'b0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (r + dr >= 0 && r + dr < H && c + dc >= 0 && c + dc < W)
              d = d | img[(r + dr) * W + c + dc];
          end
        end
        dil_s[frames * N + r * W + c] = d;
      end
    end
    frames++;
  endtask

  task automatic step(input logic pix, input logic v);
    i_pixel       = pix;
    i_pixel_valid = v;
    @(posedge clk);
    if (v) begin
      hist[acc] = pix;
      acc++;
      exp_o = (acc >= W + 3) ? dil_s[acc - W - 3] : 1'b0;
    end
    #1;
    if (v && o_pixel === 1'b1) ones++;
    check_state();
  endtask

  task automatic drive_range(input int from, input int to, input bit gate);
    for (int i = from; i < to; i++) begin
      step(img[i], 1'b1);
      if (gate) step(1'($urandom_range(1, 0)), 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_state();
    @(negedge clk);
    rst_n = 1'b1;

    load_frame(0);
    drive_range(0, N, 1'b0);
    chk("startup_idle", 16'(pixelStartUpCounter_check), 16'd10);

    ones = 0;
    load_frame(1);
    drive_range(0, 30, 1'b0);
    chk("before_first_one", 16'(o_pixel), 16'd0);
    drive_range(30, 31, 1'b0);
    chk("first_one", 16'(o_pixel), 16'd1);
    drive_range(31, N, 1'b0);

    load_frame(2);
    drive_range(0, N, 1'b0);
    load_frame(3);
    drive_range(0, N, 1'b0);
    load_frame(0);
    drive_range(0, N, 1'b0);
    chk("ones_total", 16'(ones), 16'd24);

    load_frame(1);
    drive_range(0, N, 1'b1);
    load_frame(0);
    drive_range(0, N, 1'b0);

    load_frame(1);
    drive_range(0, 40, 1'b0);
    rst_n = 1'b0;
    #1;
    acc    = 0;
    frames = 0;
    exp_o  = 1'b0;
    check_state();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    load_frame(1);
    drive_range(0, 10, 1'b0);
    chk("en_after10", 16'(pixelEnable_check), 16'd0);
    chk("su_after10", 16'(pixelStartUpCounter_check), 16'd10);
    drive_range(10, N, 1'b0);
    load_frame(0);
    drive_range(0, N, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
